// File: rtl/he_fifo_pkg.sv
// he_fifo_pkg: shared definitions for the HE gearbox coefficient FIFO.
//   - default widths, matching the he_headers values
//   - count-width and min/clamp helper functions
//   - error-cause enumeration used when reporting protocol errors
package he_fifo_pkg;

  localparam int HE_DEF_WIDTH      = 64;
  localparam int HE_DEF_WRITE_SIZE = 4;
  localparam int HE_DEF_READ_SIZE  = 8;

  // Causes of the sticky error flag (overflow, underflow, bad write count).
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2,
    ERR_CNT  = 2'd3
  } err_cause_e;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Smaller of two values; also used to clamp a request to a maximum.
  function automatic int min_u(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/param_gearbox_fifo_if.sv
// param_gearbox_fifo_if: write and read handshake bundle of the gearbox FIFO.
//   write side : data_i, wr_cnt_i, valid_i -> FIFO ; ready_o <- FIFO
//   read side  : drain_i, yumi_i -> FIFO ; valid_o, data_o, rd_cnt_o, next_data_o <- FIFO
//   modport slave is the FIFO, modport master is the producer/consumer side.
interface param_gearbox_fifo_if
  import he_fifo_pkg::*;
#(
  parameter int WIDTH      = HE_DEF_WIDTH,
  parameter int WRITE_SIZE = HE_DEF_WRITE_SIZE,
  parameter int READ_SIZE  = HE_DEF_READ_SIZE
) ();

  localparam int WCW = cnt_w(WRITE_SIZE);
  localparam int RCW = cnt_w(READ_SIZE);

  logic [WRITE_SIZE-1:0][WIDTH-1:0] data_i;
  logic [WCW-1:0]                   wr_cnt_i;
  logic                             valid_i;
  logic                             ready_o;
  logic                             drain_i;
  logic                             valid_o;
  logic [READ_SIZE-1:0][WIDTH-1:0]  data_o;
  logic [RCW-1:0]                   rd_cnt_o;
  logic [READ_SIZE-1:0][WIDTH-1:0]  next_data_o;
  logic                             yumi_i;

  modport slave (
    input  data_i, wr_cnt_i, valid_i, drain_i, yumi_i,
    output ready_o, valid_o, data_o, rd_cnt_o, next_data_o
  );

  modport master (
    output data_i, wr_cnt_i, valid_i, drain_i, yumi_i,
    input  ready_o, valid_o, data_o, rd_cnt_o, next_data_o
  );

endinterface

// File: rtl/fifo_window_read.sv
// fifo_window_read: zero-gated window of LANES words read from the storage array.
//   mem_i    : whole storage array
//   rd_ptr_i : head pointer
//   limit_i  : lane k is valid when BASE+k < limit_i, otherwise it reads as zero
//   win_o    : window, lane 0 = word at rd_ptr_i+BASE
module fifo_window_read #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 64,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int LANES     = 8,
  parameter int BASE      = 0
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic [PTR_WIDTH-1:0]        rd_ptr_i,
  input  logic [PTR_WIDTH:0]          limit_i,
  output logic [LANES-1:0][WIDTH-1:0] win_o
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int OFF = BASE + k;
    logic [PTR_WIDTH-1:0] idx_s;
    // Offset addition wraps naturally at DEPTH because DEPTH is a power of 2.
    assign idx_s    = rd_ptr_i + PTR_WIDTH'(OFF);
    assign win_o[k] = ((PTR_WIDTH + 1)'(OFF) < limit_i) ? mem_i[idx_s] : '0;
  end

endmodule

// File: rtl/param_gearbox_fifo.sv
// param_gearbox_fifo: width-converting first-word-fall-through coefficient FIFO.
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush_i        : synchronous clear of contents and error flag
//   bus            : write lanes (up to WRITE_SIZE per cycle) and READ_SIZE-word
//                    head/lookahead windows, see param_gearbox_fifo_if
//   count_o        : occupancy in words
//   err_o          : sticky protocol error (overflow, underflow, bad write count)
module param_gearbox_fifo
  import he_fifo_pkg::*;
#(
  parameter int WIDTH      = HE_DEF_WIDTH,
  parameter int WRITE_SIZE = HE_DEF_WRITE_SIZE,
  parameter int READ_SIZE  = HE_DEF_READ_SIZE,
  parameter int DEPTH      = 64,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  param_gearbox_fifo_if.slave bus,
  output logic [PTR_WIDTH:0]  count_o,
  output logic                err_o
);

  localparam int CW  = PTR_WIDTH + 1;
  localparam int WCW = cnt_w(WRITE_SIZE);
  localparam int RCW = cnt_w(READ_SIZE);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        err_q, err_d;

  logic           ready_s, valid_s, wr_fire_s, rd_fire_s, cnt_bad_s;
  logic [WCW-1:0] wr_cnt_s;
  logic [RCW-1:0] rd_cnt_s;
  logic [CW-1:0]  wr_acc_s, rd_acc_s, head_lim_s, next_lim_s;

  // Handshake qualifiers and head window size, from registered state only.
  always_comb begin
    ready_s  = 1'b0;
    valid_s  = 1'b0;
    rd_cnt_s = '0;
    if (reset_i) begin
      ready_s  = 1'b0;
      valid_s  = 1'b0;
      rd_cnt_s = '0;
    end else begin
      ready_s = (count_q <= CW'(DEPTH - WRITE_SIZE));
      valid_s = (count_q >= CW'(READ_SIZE)) || (bus.drain_i && (count_q != '0));
      if (valid_s) begin
        rd_cnt_s = RCW'(min_u(32'(count_q), READ_SIZE));
      end else begin
        rd_cnt_s = '0;
      end
    end
  end

  // Accepted transfer sizes and next state of pointers, occupancy and error flag.
  always_comb begin
    cnt_bad_s = (bus.wr_cnt_i > WCW'(WRITE_SIZE));
    wr_cnt_s  = WCW'(min_u(32'(bus.wr_cnt_i), WRITE_SIZE));
    wr_fire_s = bus.valid_i && ready_s && (wr_cnt_s != '0);
    rd_fire_s = bus.yumi_i && valid_s;
    wr_acc_s  = '0;
    rd_acc_s  = '0;
    if (wr_fire_s) begin
      wr_acc_s = CW'(wr_cnt_s);
    end else begin
      wr_acc_s = '0;
    end
    if (rd_fire_s) begin
      rd_acc_s = CW'(rd_cnt_s);
    end else begin
      rd_acc_s = '0;
    end
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_acc_s);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(rd_acc_s);
    // Write space is checked against the pre-read count, so this cannot wrap.
    count_d  = count_q + wr_acc_s - rd_acc_s;
    err_d    = err_q
             || (bus.valid_i && !ready_s)
             || (bus.valid_i && cnt_bad_s)
             || (bus.yumi_i && !valid_s);
  end

  // State registers; reset and flush both empty the FIFO and clear the error.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage write; only the accepted lanes are stored, the array is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire_s && !flush_i) begin
      for (int k = 0; k < WRITE_SIZE; k++) begin
        if (WCW'(k) < wr_cnt_s) begin
          mem_q[wr_ptr_q + PTR_WIDTH'(k)] <= bus.data_i[k];
        end
      end
    end
  end

  // Head window is gated by rd_cnt; lookahead is gated by occupancy alone.
  assign head_lim_s = CW'(rd_cnt_s);
  assign next_lim_s = reset_i ? '0 : count_q;

  fifo_window_read #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH),
    .LANES(READ_SIZE), .BASE(0)
  ) u_head (
    .mem_i(mem_q), .rd_ptr_i(rd_ptr_q), .limit_i(head_lim_s), .win_o(bus.data_o)
  );

  fifo_window_read #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH),
    .LANES(READ_SIZE), .BASE(READ_SIZE)
  ) u_next (
    .mem_i(mem_q), .rd_ptr_i(rd_ptr_q), .limit_i(next_lim_s), .win_o(bus.next_data_o)
  );

  assign bus.ready_o  = ready_s;
  assign bus.valid_o  = valid_s;
  assign bus.rd_cnt_o = rd_cnt_s;
  assign count_o      = count_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_param_gearbox_fifo.sv
// tb_param_gearbox_fifo: self-checking bench for param_gearbox_fifo
// (WIDTH=32, WRITE_SIZE=4, READ_SIZE=8, DEPTH=16).
module tb_param_gearbox_fifo;
  import he_fifo_pkg::*;

  localparam int W  = 32;
  localparam int WS = 4;
  localparam int RS = 8;
  localparam int D  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [4:0] count;
  logic       err;

  always #5 clk = ~clk;

  param_gearbox_fifo_if #(.WIDTH(W), .WRITE_SIZE(WS), .READ_SIZE(RS)) bus ();

  param_gearbox_fifo #(
    .WIDTH(W), .WRITE_SIZE(WS), .READ_SIZE(RS), .DEPTH(D)
  ) dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .bus(bus),
    .count_o(count), .err_o(err)
  );

  int passed = 0;
  int total  = 0;
  int unsigned mq[$];   // reference word queue for the table phase
  int unsigned sb[$];   // scoreboard of words expected on data_o

  typedef struct {
    logic        valid;
    logic [2:0]  wcnt;
    int unsigned base;
    logic        yumi;
    logic        flush;
    logic        drain;
    int unsigned e_count;
    logic        e_valid;
    int unsigned e_rdcnt;
    logic        e_ready;
    logic        e_err;
    err_cause_e  cause;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [127:0] lanes4(input int unsigned b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = b + k;
    return r;
  endfunction

  function automatic logic [255:0] seqwin(input int unsigned b, input int n);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = (k < n) ? b + k : 32'd0;
    return r;
  endfunction

  // Window of the reference queue: lane k = mq[off+k] when off+k < lim.
  function automatic logic [255:0] m_win(input int off, input int lim);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = (off + k < lim) ? mq[off + k] : 32'd0;
    return r;
  endfunction

  // Advance the reference queue by one clock of the given row.
  task automatic model_step(input vec_t r);
    int n = mq.size();
    bit mv;
    int rc;
    int wn;
    mv = (n >= RS) || (r.drain && n > 0);
    rc = mv ? ((n < RS) ? n : RS) : 0;
    wn = (int'(r.wcnt) > WS) ? WS : int'(r.wcnt);
    if (r.flush) begin
      mq.delete();
    end else begin
      if (r.yumi && mv) repeat (rc) void'(mq.pop_front());
      if (r.valid && (D - n) >= WS) for (int k = 0; k < wn; k++) mq.push_back(r.base + k);
    end
  endtask

  // One clock, then return the one-shot inputs to idle and let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
    bus.valid_i  = 1'b0;
    bus.yumi_i   = 1'b0;
    bus.wr_cnt_i = 3'd0;
    flush        = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [2:0] n, input int unsigned base);
    bus.valid_i  = 1'b1;
    bus.wr_cnt_i = n;
    bus.data_i   = lanes4(base);
    step();
  endtask

  task automatic chk_forced(input string nm);
    chk({nm, " ready"},  256'(bus.ready_o),  256'(0));
    chk({nm, " valid"},  256'(bus.valid_o),  256'(0));
    chk({nm, " rd_cnt"}, 256'(bus.rd_cnt_o), 256'(0));
    chk({nm, " data"},   bus.data_o,         256'(0));
    chk({nm, " next"},   bus.next_data_o,    256'(0));
  endtask

  initial begin
    int w;
    int wins;
    int n;
    int hn;
    int hc;
    bit hv;
    logic [255:0] ew;
    vec_t r;

    //      valid wcnt base yumi flush drain | count valid rdcnt ready err cause
    tbl[0]  = '{1'b1, 3'd4,  0, 1'b0, 1'b0, 1'b0,  4, 1'b0, 0, 1'b1, 1'b0, ERR_NONE};
    tbl[1]  = '{1'b1, 3'd4,  4, 1'b0, 1'b0, 1'b0,  8, 1'b1, 8, 1'b1, 1'b0, ERR_NONE};
    tbl[2]  = '{1'b1, 3'd4,  8, 1'b0, 1'b0, 1'b0, 12, 1'b1, 8, 1'b1, 1'b0, ERR_NONE};
    tbl[3]  = '{1'b1, 3'd4, 12, 1'b0, 1'b0, 1'b0, 16, 1'b1, 8, 1'b0, 1'b0, ERR_NONE};
    tbl[4]  = '{1'b1, 3'd4, 16, 1'b0, 1'b0, 1'b0, 16, 1'b1, 8, 1'b0, 1'b1, ERR_OVF};
    tbl[5]  = '{1'b0, 3'd0,  0, 1'b0, 1'b1, 1'b0,  0, 1'b0, 0, 1'b1, 1'b0, ERR_NONE};
    tbl[6]  = '{1'b1, 3'd4,  0, 1'b0, 1'b0, 1'b0,  4, 1'b0, 0, 1'b1, 1'b0, ERR_NONE};
    tbl[7]  = '{1'b1, 3'd4,  4, 1'b0, 1'b0, 1'b0,  8, 1'b1, 8, 1'b1, 1'b0, ERR_NONE};
    tbl[8]  = '{1'b1, 3'd4,  8, 1'b0, 1'b0, 1'b0, 12, 1'b1, 8, 1'b1, 1'b0, ERR_NONE};
    tbl[9]  = '{1'b1, 3'd4, 12, 1'b1, 1'b0, 1'b0,  8, 1'b1, 8, 1'b1, 1'b0, ERR_NONE};
    tbl[10] = '{1'b1, 3'd5, 16, 1'b0, 1'b0, 1'b0, 12, 1'b1, 8, 1'b1, 1'b1, ERR_CNT};
    tbl[11] = '{1'b0, 3'd0,  0, 1'b1, 1'b0, 1'b0,  4, 1'b0, 0, 1'b1, 1'b1, ERR_CNT};
    tbl[12] = '{1'b0, 3'd0,  0, 1'b0, 1'b0, 1'b1,  4, 1'b1, 4, 1'b1, 1'b1, ERR_CNT};
    tbl[13] = '{1'b0, 3'd0,  0, 1'b0, 1'b0, 1'b0,  4, 1'b0, 0, 1'b1, 1'b1, ERR_CNT};
    tbl[14] = '{1'b1, 3'd2, 20, 1'b0, 1'b0, 1'b0,  6, 1'b0, 0, 1'b1, 1'b1, ERR_CNT};
    tbl[15] = '{1'b0, 3'd0,  0, 1'b1, 1'b0, 1'b1,  0, 1'b0, 0, 1'b1, 1'b1, ERR_CNT};
    tbl[16] = '{1'b0, 3'd0,  0, 1'b0, 1'b1, 1'b0,  0, 1'b0, 0, 1'b1, 1'b0, ERR_NONE};
    tbl[17] = '{1'b0, 3'd0,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 0, 1'b1, 1'b1, ERR_UNF};
    tbl[18] = '{1'b0, 3'd0,  0, 1'b0, 1'b1, 1'b0,  0, 1'b0, 0, 1'b1, 1'b0, ERR_NONE};
    tbl[19] = '{1'b1, 3'd0, 40, 1'b0, 1'b0, 1'b0,  0, 1'b0, 0, 1'b1, 1'b0, ERR_NONE};

    rst = 1'b1; flush = 1'b0;
    bus.valid_i = 1'b1; bus.wr_cnt_i = 3'd4; bus.data_i = lanes4(50);
    bus.yumi_i = 1'b1; bus.drain_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_forced("in_reset");
    rst = 1'b0; bus.valid_i = 1'b0; bus.yumi_i = 1'b0; bus.drain_i = 1'b0; bus.wr_cnt_i = 3'd0;
    #1;
    chk("post_reset ready", 256'(bus.ready_o), 256'(1));
    chk("post_reset count", 256'(count), 256'(0));
    chk("post_reset err",   256'(err),   256'(0));
    chk("post_reset valid", 256'(bus.valid_o), 256'(0));

    // Two full writes form one complete window.
    wr(3'd4, 4);
    wr(3'd4, 0);
    chk("s1 valid",  256'(bus.valid_o),  256'(1));
    chk("s1 rd_cnt", 256'(bus.rd_cnt_o), 256'(8));
    chk("s1 data",   bus.data_o,         seqwin(4, 4) | (seqwin(0, 4) << 128));
    chk("s1 next",   bus.next_data_o,    256'(0));
    chk("s1 count",  256'(count),        256'(8));
    chk("s1 ready",  256'(bus.ready_o),  256'(1));
    bus.yumi_i = 1'b1; step();
    chk("s1 drained", 256'(count), 256'(0));

    // Partial write, exposed only by drain.
    wr(3'd3, 10);
    chk("s2 count",      256'(count),       256'(3));
    chk("s2 valid",      256'(bus.valid_o), 256'(0));
    chk("s2 data gated", bus.data_o,        256'(0));
    bus.drain_i = 1'b1; #1;
    chk("s2 drain valid",  256'(bus.valid_o),  256'(1));
    chk("s2 drain rd_cnt", 256'(bus.rd_cnt_o), 256'(3));
    chk("s2 drain data",   bus.data_o,         seqwin(10, 3));
    bus.yumi_i = 1'b1; step();
    chk("s2 count", 256'(count),       256'(0));
    chk("s2 valid", 256'(bus.valid_o), 256'(0));
    chk("s2 err",   256'(err),         256'(0));
    bus.drain_i = 1'b0;

    // Table phase: fill, overflow, flush, simultaneous read/write, clamp, drain, underflow.
    mq.delete();
    for (int i = 0; i < 20; i++) begin
      r = tbl[i];
      bus.valid_i = r.valid; bus.wr_cnt_i = r.wcnt; bus.data_i = lanes4(r.base);
      bus.yumi_i = r.yumi; flush = r.flush; bus.drain_i = r.drain;
      model_step(r);
      step();
      hn = mq.size();
      hv = (hn >= RS) || (r.drain && hn > 0);
      hc = hv ? ((hn < RS) ? hn : RS) : 0;
      chk($sformatf("row%0d count", i),  256'(count),        256'(r.e_count));
      chk($sformatf("row%0d valid", i),  256'(bus.valid_o),  256'(r.e_valid));
      chk($sformatf("row%0d rd_cnt", i), 256'(bus.rd_cnt_o), 256'(r.e_rdcnt));
      chk($sformatf("row%0d ready", i),  256'(bus.ready_o),  256'(r.e_ready));
      chk($sformatf("row%0d err %s", i, r.cause.name()), 256'(err), 256'(r.e_err));
      chk($sformatf("row%0d data", i),   bus.data_o,        m_win(0, hc));
      chk($sformatf("row%0d next", i),   bus.next_data_o,   m_win(RS, hn));
    end
    bus.drain_i = 1'b0;

    // Stream 0..39 with random lane counts and reads whenever a window is up.
    sb.delete();
    w = 0; wins = 0;
    for (int cyc = 0; cyc < 300 && wins < 5; cyc++) begin
      n = (w < 40) ? int'($urandom_range(1, 4)) : 0;
      if (n > 40 - w) n = 40 - w;
      bus.valid_i = (n != 0); bus.wr_cnt_i = 3'(n); bus.data_i = lanes4(w);
      #1;
      chk("stream count", 256'(count),       256'(sb.size()));
      chk("stream valid", 256'(bus.valid_o), 256'(sb.size() >= 8));
      chk("stream ready", 256'(bus.ready_o), 256'((D - sb.size()) >= WS));
      if (sb.size() >= 8) begin
        bus.yumi_i = 1'b1;
        for (int k = 0; k < 8; k++) ew[k*32 +: 32] = sb[k];
        chk($sformatf("stream window%0d", wins), bus.data_o, ew);
        repeat (8) void'(sb.pop_front());
        wins++;
      end
      if (n != 0 && (D - sb.size() - ((bus.yumi_i) ? 0 : 0)) >= 0 && bus.ready_o) begin
        for (int k = 0; k < n; k++) sb.push_back(w + k);
        w += n;
      end
      step();
    end
    chk("stream windows", 256'(wins), 256'(5));
    chk("stream empty",   256'(count), 256'(0));
    chk("stream err",     256'(err),   256'(0));

    // Flush at count 8 with an error pending, alongside a write and a read.
    wr(3'd4, 100);
    wr(3'd7, 104);
    chk("s6 count", 256'(count), 256'(8));
    chk("s6 err",   256'(err),   256'(1));
    chk("s6 data",  bus.data_o,  seqwin(100, 8));
    flush = 1'b1; bus.valid_i = 1'b1; bus.wr_cnt_i = 3'd4; bus.data_i = lanes4(200);
    bus.yumi_i = 1'b1;
    step();
    chk("s6 flush count", 256'(count),       256'(0));
    chk("s6 flush err",   256'(err),         256'(0));
    chk("s6 flush valid", 256'(bus.valid_o), 256'(0));
    step();
    chk("s6 write discarded", 256'(count), 256'(0));

    // Reset in the middle of traffic.
    wr(3'd4, 300);
    rst = 1'b1; bus.valid_i = 1'b1; bus.wr_cnt_i = 3'd4; bus.yumi_i = 1'b1; bus.drain_i = 1'b1;
    #1;
    chk_forced("mid_reset");
    step();
    chk_forced("mid_reset held");
    chk("mid_reset count", 256'(count), 256'(0));
    rst = 1'b0; #1;
    chk("after_reset count", 256'(count),       256'(0));
    chk("after_reset err",   256'(err),         256'(0));
    chk("after_reset ready", 256'(bus.ready_o), 256'(1));
    chk("after_reset valid", 256'(bus.valid_o), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_gearbox_fifo.md
Name: param_gearbox_fifo

Overview:
- Next-generation width-converting coefficient FIFO for the HE datapath.
- Accepts up to WRITE_SIZE words per cycle, with a variable lane count, and presents READ_SIZE-word windows with first-word-fall-through.
- Adds three capabilities:
  - drain mode, which emits a partial final window;
  - an occupancy output;
  - a sticky protocol-error flag, with flush.
- Sits between NTT/coefficient producers and consumers whose vector widths differ.

Parameters:
- WIDTH, 64, bits per coefficient word.
- WRITE_SIZE, 4, max words accepted per write.
- READ_SIZE, 8, words per output window.
- DEPTH, 64, storage in words. Must be a power of 2, ≥ 2*READ_SIZE, and ≥ READ_SIZE+WRITE_SIZE.
- PTR_WIDTH, $clog2(DEPTH), pointer width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of contents and error flag.
- data_i  in  WRITE_SIZE×WIDTH  write lanes; lane 0 is oldest.
- wr_cnt_i  in  $clog2(WRITE_SIZE)+1  number of valid lanes (0..WRITE_SIZE).
- valid_i  in  1  write request.
- ready_o  out  1  free space ≥ WRITE_SIZE.
- drain_i  in  1  permits a partial window.
- valid_o  out  1  window available.
- data_o  out  READ_SIZE×WIDTH  head window; lane 0 is oldest.
- rd_cnt_o  out  $clog2(READ_SIZE)+1  valid lanes in data_o.
- next_data_o  out  READ_SIZE×WIDTH  lookahead window, words head+READ_SIZE onward.
- yumi_i  in  1  consume the current window.
- count_o  out  PTR_WIDTH+1  occupancy in words.
- err_o  out  1  sticky protocol error.

Behaviour:
- **Storage:** DEPTH-word array, plus wr_ptr, rd_ptr and count registers. Pointers wrap modulo DEPTH. The array is not reset.
- **Reset:**
  - reset_i high sets wr_ptr, rd_ptr, count and err to 0 at the clock edge. reset_i has priority over everything else.
  - While reset_i is high: ready_o=0, valid_o=0, rd_cnt_o=0, data_o and next_data_o are all zero.
  - Cycle after reset deasserts: ready_o=1, count_o=0.
- **flush_i:** same register effect as reset. Priority is below reset_i and above valid_i/yumi_i. Any write or read in that cycle is discarded. Outputs are not forced during the flush cycle.
- **ready_o:** (DEPTH − count) ≥ WRITE_SIZE, from registered count only. No combinational path from yumi_i.
- **Write:** when valid_i && ready_o && wr_cnt_i≠0:
  - lane k goes to mem[wr_ptr+k] for k < wr_cnt_i;
  - wr_ptr += wr_cnt_i.
  - Data appears on the outputs the next cycle (latency 1).
- **wr_cnt_i > WRITE_SIZE:** clamped to WRITE_SIZE, err set.
- **valid_i && !ready_o:** write dropped, err set.
- **Output window (combinational from registers):**
  - valid_o = (count ≥ READ_SIZE) || (drain_i && count > 0).
  - rd_cnt_o = valid_o ? min(count, READ_SIZE) : 0.
  - data_o lane k = mem[rd_ptr+k] if k < rd_cnt_o, else 0.
  - next_data_o lane k = mem[rd_ptr+READ_SIZE+k] if READ_SIZE+k < count, else 0. It is independent of valid_o.
- **Read:**
  - yumi_i && valid_o: rd_ptr += rd_cnt_o.
  - yumi_i && !valid_o: ignored, err set.
- **Simultaneous read and write:** allowed. count_next = count + wcnt_accepted − rcnt_consumed. This can never underflow or overflow.
- **Error flag:** err_o is registered and sticky. It is cleared only by reset_i or flush_i.
- **drain_i:** purely combinational qualifier. Deasserting it with a partial window pending drops valid_o without loss of data.

Decomposition:
- Defaults for WIDTH/WRITE_SIZE/READ_SIZE come from the existing he_headers macros (BIT_WIDTH, WRITE_SIZE, READ_SIZE).
- New package he_fifo_pkg holds:
  - count-width helper functions (cnt_w(n) = $clog2(n)+1);
  - min/clamp function;
  - an error-cause enum (ERR_OVF, ERR_UNF, ERR_CNT) for bench messages.
- One sub-module, fifo_window_read. Parameters: base offset, lane count, limit. It produces a zero-gated window from mem, rd_ptr and count, and is instantiated twice (data_o, next_data_o).

Test Plan:
All scenarios use WIDTH=32, WRITE_SIZE=4, READ_SIZE=8, DEPTH=16.
1. Reset, then write {4,5,6,7} and {0,1,2,3} with wr_cnt=4 → next cycle: valid_o=1, rd_cnt_o=8, data_o={4,5,6,7,0,1,2,3}, count_o=8, ready_o=1.
2. Write {A,B,C,D} with wr_cnt=3 → count_o=3, valid_o=0. Raise drain_i → valid_o=1, rd_cnt_o=3, data_o={A,B,C,0,0,0,0,0}. Pulse yumi_i → count_o=0, valid_o=0, err_o=0.
3. Four full writes (words 0..15) → ready_o=1 at count 12 and 0 at count 16. Write attempt while full → dropped, err_o=1, count_o=16. Meanwhile data_o=0..7 and next_data_o=8..15.
4. Hold 0..11 (count 12), then assert yumi_i together with a write of {12,13,14,15} → count_o=8, data_o={8..15}, next_data_o all zero.
5. Stream 0..39 through, with wrap and continuous reads (yumi_i whenever valid_o) → windows {0..7},{8..15},…,{32..39} in order, with no loss or duplication across pointer wrap.
6. With count 8, assert flush_i together with valid_i and yumi_i, and err_o=1 → next cycle: count_o=0, err_o=0, valid_o=0, write discarded. Repeat with reset_i mid-stream → outputs forced to zero during reset, same end state.
